// File: rtl/i3c_resp_desc_gen.sv
// Response descriptor writer: tracks one in-flight command, counts data bytes,
// latches the first error and pushes one 32-bit response descriptor on a valid/ready port.
module i3c_resp_desc_gen #(
   parameter bit CntSat = 1'b1
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        cmd_start_i,
   output logic        cmd_ready_o,
   input  logic [3:0]  cmd_tid_i,
   input  logic        cmd_wroc_i,
   input  logic        cmd_rnw_i,
   input  logic        cmd_sre_i,
   input  logic [15:0] cmd_len_i,
   input  logic        byte_xfer_i,
   input  logic        err_i,
   input  logic [3:0]  err_code_i,
   input  logic        abort_i,
   input  logic        cmd_done_i,
   output logic        resp_valid_o,
   input  logic        resp_ready_i,
   output logic [31:0] resp_desc_o,
   output logic        busy_o
);

   localparam int unsigned LenW = 16;
   localparam int unsigned TidW = 4;
   localparam int unsigned ErrW = 4;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ACTIVE = 2'd1;
   localparam logic [1:0] ST_PUSH   = 2'd2;

   localparam logic [ErrW-1:0] ERR_SUCCESS    = 4'h0;
   localparam logic [ErrW-1:0] ERR_SHORT_READ = 4'h7;
   localparam logic [ErrW-1:0] ERR_HC_ABORTED = 4'h8;

   logic [1:0]      state_q,   state_n;
   logic [TidW-1:0] tid_q,     tid_n;
   logic            wroc_q,    wroc_n;
   logic            rnw_q,     rnw_n;
   logic            sre_q,     sre_n;
   logic [LenW-1:0] len_q,     len_n;
   logic [LenW-1:0] count_q,   count_n;
   logic [ErrW-1:0] err_q,     err_n;
   logic            valid_n;
   logic [31:0]     desc_n;

   logic [LenW-1:0] count_inc;
   logic [ErrW-1:0] err_upd;
   logic [ErrW-1:0] final_err;

   // State and latch registers; outputs are registered copies of the next-state decode
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= ST_IDLE;
         tid_q        <= '0;
         wroc_q       <= 1'b0;
         rnw_q        <= 1'b0;
         sre_q        <= 1'b0;
         len_q        <= '0;
         count_q      <= '0;
         err_q        <= ERR_SUCCESS;
         resp_valid_o <= 1'b0;
         resp_desc_o  <= '0;
         cmd_ready_o  <= 1'b1;
         busy_o       <= 1'b0;
      end else begin
         state_q      <= state_n;
         tid_q        <= tid_n;
         wroc_q       <= wroc_n;
         rnw_q        <= rnw_n;
         sre_q        <= sre_n;
         len_q        <= len_n;
         count_q      <= count_n;
         err_q        <= err_n;
         resp_valid_o <= valid_n;
         resp_desc_o  <= desc_n;
         cmd_ready_o  <= (state_n == ST_IDLE);
         busy_o       <= (state_n != ST_IDLE);
      end
   end

   // Next-state decode; same-cycle byte/error/abort are folded into the completion status
   always_comb begin
      state_n   = state_q;
      tid_n     = tid_q;
      wroc_n    = wroc_q;
      rnw_n     = rnw_q;
      sre_n     = sre_q;
      len_n     = len_q;
      count_n   = count_q;
      err_n     = err_q;
      valid_n   = resp_valid_o;
      desc_n    = resp_desc_o;
      count_inc = count_q;
      err_upd   = err_q;
      final_err = err_q;

      if (byte_xfer_i) begin
         if (CntSat && (count_q == {LenW{1'b1}})) count_inc = count_q;
         else                                     count_inc = count_q + LenW'(1);
      end

      if (abort_i)                                 err_upd = ERR_HC_ABORTED;
      else if (err_i && (err_q == ERR_SUCCESS))    err_upd = err_code_i;

      final_err = err_upd;
      if ((err_upd == ERR_SUCCESS) && rnw_q && sre_q && (count_inc < len_q))
         final_err = ERR_SHORT_READ;

      case (state_q)
         ST_IDLE: begin
            if (cmd_start_i) begin
               tid_n   = cmd_tid_i;
               wroc_n  = cmd_wroc_i;
               rnw_n   = cmd_rnw_i;
               sre_n   = cmd_sre_i;
               len_n   = cmd_len_i;
               count_n = '0;
               err_n   = ERR_SUCCESS;
               state_n = ST_ACTIVE;
            end
         end
         ST_ACTIVE: begin
            count_n = count_inc;
            err_n   = err_upd;
            if (cmd_done_i) begin
               if (wroc_q || (final_err != ERR_SUCCESS)) begin
                  desc_n  = {final_err, tid_q, 8'h00, count_inc};
                  valid_n = 1'b1;
                  state_n = ST_PUSH;
               end else begin
                  state_n = ST_IDLE;
               end
            end
         end
         ST_PUSH: begin
            if (resp_ready_i) begin
               valid_n = 1'b0;
               state_n = ST_IDLE;
            end
         end
         default: begin
            valid_n = 1'b0;
            state_n = ST_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_i3c_resp_desc_gen.sv
// Bench for i3c_resp_desc_gen: directed scenarios plus randomized commands checked
// against an aggregate model of the response rules.
module tb_i3c_resp_desc_gen;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cmd_start = 1'b0;
   logic        cmd_ready;
   logic [3:0]  cmd_tid = '0;
   logic        cmd_wroc = 1'b0;
   logic        cmd_rnw = 1'b0;
   logic        cmd_sre = 1'b0;
   logic [15:0] cmd_len = '0;
   logic        byte_xfer = 1'b0;
   logic        err = 1'b0;
   logic [3:0]  err_code = '0;
   logic        abort = 1'b0;
   logic        cmd_done = 1'b0;
   logic        resp_valid;
   logic        resp_ready = 1'b0;
   logic [31:0] resp_desc;
   logic        busy;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   i3c_resp_desc_gen #(.CntSat(1'b1)) dut (
      .clk_i(clk), .rst_i(rst),
      .cmd_start_i(cmd_start), .cmd_ready_o(cmd_ready),
      .cmd_tid_i(cmd_tid), .cmd_wroc_i(cmd_wroc), .cmd_rnw_i(cmd_rnw),
      .cmd_sre_i(cmd_sre), .cmd_len_i(cmd_len),
      .byte_xfer_i(byte_xfer), .err_i(err), .err_code_i(err_code),
      .abort_i(abort), .cmd_done_i(cmd_done),
      .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
      .resp_desc_o(resp_desc), .busy_o(busy)
   );

   // Reference: status from aggregate history (abort wins, else first non-zero error,
   // else short-read rule); length is the saturated byte total.
   function automatic logic [32:0] model(input logic [3:0] tid, input logic wroc,
                                         input logic rnw, input logic sre,
                                         input int len, input int nbytes,
                                         input logic [3:0] first_err, input logic aborted);
      logic [3:0]  st;
      logic [15:0] cnt;
      logic        emit;
      st = aborted ? 4'h8 : first_err;
      if (st == 4'h0 && rnw && sre && nbytes < len) st = 4'h7;
      cnt  = (nbytes > 65535) ? 16'hFFFF : 16'(nbytes);
      emit = wroc || (st != 4'h0);
      return {emit, st, tid, 8'h00, cnt};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [3:0] tid, input logic wroc, input logic rnw,
                        input logic sre, input logic [15:0] len);
      cmd_tid = tid; cmd_wroc = wroc; cmd_rnw = rnw; cmd_sre = sre; cmd_len = len;
      cmd_start = 1'b1;
      tick();
      cmd_start = 1'b0;
   endtask

   task automatic step(input logic bx, input logic e, input logic [3:0] ec,
                       input logic ab, input logic done);
      byte_xfer = bx; err = e; err_code = ec; abort = ab; cmd_done = done;
      tick();
      byte_xfer = 1'b0; err = 1'b0; err_code = '0; abort = 1'b0; cmd_done = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      checks++;
      if (resp_valid !== 1'b0 || resp_desc !== 32'h0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset: valid=%b desc=%h busy=%b ready=%b required 0 00000000 0 1",
                  resp_valid, resp_desc, busy, cmd_ready);
      end
      step(1'b1, 1'b1, 4'h5, 1'b1, 1'b1);
      checks++;
      if (resp_valid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL idle_ignore: valid=%b busy=%b required 0 0", resp_valid, busy);
      end
   endtask

   task automatic test_write_wroc();
      logic [32:0] exp;
      issue(4'd3, 1'b1, 1'b0, 1'b0, 16'd4);
      checks++;
      if (busy !== 1'b1 || cmd_ready !== 1'b0) begin
         errors++;
         $display("FAIL t1_busy: busy=%b ready=%b required 1 0", busy, cmd_ready);
      end
      repeat (4) step(1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
      checks++;
      if (resp_valid !== 1'b0) begin
         errors++;
         $display("FAIL t1_early_valid: valid=%b required 0", resp_valid);
      end
      step(1'b0, 1'b0, 4'h0, 1'b0, 1'b1);
      exp = model(4'd3, 1'b1, 1'b0, 1'b0, 4, 4, 4'h0, 1'b0);
      checks++;
      if (resp_valid !== 1'b1 || resp_desc !== exp[31:0] || exp[31:0] !== 32'h0300_0004) begin
         errors++;
         $display("FAIL t1_desc: valid=%b desc=%h required 1 %h", resp_valid, resp_desc, exp[31:0]);
      end
      resp_ready = 1'b1;
      tick();
      resp_ready = 1'b0;
      checks++;
      if (resp_valid !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL t1_accept: valid=%b ready=%b busy=%b required 0 1 0",
                  resp_valid, cmd_ready, busy);
      end
   endtask

   task automatic test_short_read();
      for (int w = 1; w >= 0; w--) begin
         issue(4'd5, 1'(w), 1'b1, 1'b1, 16'd8);
         repeat (3) step(1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
         step(1'b0, 1'b0, 4'h0, 1'b0, 1'b1);
         checks++;
         if (resp_valid !== 1'b1 || resp_desc !== 32'h7500_0003) begin
            errors++;
            $display("FAIL t2_short_read wroc=%0d: valid=%b desc=%h required 1 75000003",
                     w, resp_valid, resp_desc);
         end
         resp_ready = 1'b1; tick(); resp_ready = 1'b0;
      end
      // Full-length read with sre is not short
      issue(4'd6, 1'b1, 1'b1, 1'b1, 16'd2);
      step(1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 4'h0, 1'b0, 1'b1);
      checks++;
      if (resp_valid !== 1'b1 || resp_desc !== 32'h0600_0002) begin
         errors++;
         $display("FAIL t2_full_read: valid=%b desc=%h required 1 06000002", resp_valid, resp_desc);
      end
      resp_ready = 1'b1; tick(); resp_ready = 1'b0;
   endtask

   task automatic test_no_resp();
      issue(4'd2, 1'b0, 1'b0, 1'b0, 16'd9);
      repeat (2) step(1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 4'h0, 1'b0, 1'b1);
      checks++;
      if (resp_valid !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
         errors++;
         $display("FAIL t3_no_resp: valid=%b busy=%b ready=%b required 0 0 1",
                  resp_valid, busy, cmd_ready);
      end
   endtask

   task automatic test_errors();
      issue(4'd1, 1'b1, 1'b0, 1'b0, 16'd0);
      step(1'b0, 1'b1, 4'h5, 1'b0, 1'b0);
      step(1'b0, 1'b1, 4'h6, 1'b0, 1'b0);
      step(1'b0, 1'b0, 4'h0, 1'b0, 1'b1);
      checks++;
      if (resp_valid !== 1'b1 || resp_desc !== 32'h5100_0000) begin
         errors++;
         $display("FAIL t4_first_err: valid=%b desc=%h required 1 51000000", resp_valid, resp_desc);
      end
      resp_ready = 1'b1; tick(); resp_ready = 1'b0;

      issue(4'd1, 1'b0, 1'b0, 1'b0, 16'd0);
      step(1'b0, 1'b1, 4'h5, 1'b0, 1'b0);
      step(1'b0, 1'b0, 4'h0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 4'h0, 1'b0, 1'b1);
      checks++;
      if (resp_valid !== 1'b1 || resp_desc !== 32'h8100_0000) begin
         errors++;
         $display("FAIL t4_abort: valid=%b desc=%h required 1 81000000", resp_valid, resp_desc);
      end
      resp_ready = 1'b1; tick(); resp_ready = 1'b0;

      // Byte and error arriving in the done cycle both count
      issue(4'd9, 1'b0, 1'b0, 1'b0, 16'd0);
      step(1'b1, 1'b1, 4'h3, 1'b0, 1'b1);
      checks++;
      if (resp_valid !== 1'b1 || resp_desc !== 32'h3900_0001) begin
         errors++;
         $display("FAIL t4_same_cycle: valid=%b desc=%h required 1 39000001", resp_valid, resp_desc);
      end
      resp_ready = 1'b1; tick(); resp_ready = 1'b0;
   endtask

   task automatic test_backpressure();
      logic [31:0] first;
      int bad;
      bad = 0;
      issue(4'hA, 1'b1, 1'b0, 1'b0, 16'd1);
      step(1'b1, 1'b0, 4'h0, 1'b0, 1'b1);
      first = resp_desc;
      checks++;
      if (first !== 32'h0A00_0001) begin
         errors++;
         $display("FAIL t5_desc: desc=%h required 0a000001", first);
      end
      cmd_tid = 4'h7; cmd_wroc = 1'b1; cmd_len = 16'd3; cmd_start = 1'b1;
      for (int i = 0; i < 10; i++) begin
         byte_xfer = 1'b1; err = 1'b1; err_code = 4'h4; abort = 1'b1; cmd_done = 1'b1;
         tick();
         checks++;
         if (resp_valid !== 1'b1 || resp_desc !== 32'h0A00_0001 || cmd_ready !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL t5_hold cyc=%0d: valid=%b desc=%h ready=%b busy=%b required 1 0a000001 0 1",
                     i, resp_valid, resp_desc, cmd_ready, busy);
         end
      end
      byte_xfer = 1'b0; err = 1'b0; err_code = '0; abort = 1'b0; cmd_done = 1'b0;
      resp_ready = 1'b1;
      tick();
      resp_ready = 1'b0;
      cmd_start = 1'b0;
      checks++;
      if (resp_valid !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL t5_release: valid=%b ready=%b busy=%b required 0 1 0",
                  resp_valid, cmd_ready, busy);
      end
      tick();
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL t5_bubble: busy=%b required 0", busy);
      end
   endtask

   task automatic test_saturation();
      logic [32:0] exp;
      issue(4'd4, 1'b1, 1'b0, 1'b0, 16'd0);
      byte_xfer = 1'b1;
      repeat (65537) @(posedge clk);
      #1;
      byte_xfer = 1'b0;
      step(1'b0, 1'b0, 4'h0, 1'b0, 1'b1);
      exp = model(4'd4, 1'b1, 1'b0, 1'b0, 0, 65537, 4'h0, 1'b0);
      checks++;
      if (resp_valid !== 1'b1 || resp_desc !== exp[31:0]) begin
         errors++;
         $display("FAIL t6_saturate: valid=%b desc=%h required 1 %h", resp_valid, resp_desc, exp[31:0]);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if (resp_valid !== 1'b0 || resp_desc !== 32'h0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
         errors++;
         $display("FAIL t6_reset_push: valid=%b desc=%h busy=%b ready=%b required 0 00000000 0 1",
                  resp_valid, resp_desc, busy, cmd_ready);
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 40; n++) begin
         logic [3:0]  tid, ferr, ec;
         logic        wroc, rnw, sre, aborted, bx, e, ab;
         logic [15:0] len;
         int          nbytes, ncyc, dly;
         logic [32:0] exp;
         tid = 4'($urandom); wroc = 1'($urandom); rnw = 1'($urandom); sre = 1'($urandom);
         len = 16'($urandom_range(0, 6));
         nbytes = 0; ferr = 4'h0; aborted = 1'b0;
         issue(tid, wroc, rnw, sre, len);
         ncyc = $urandom_range(0, 6);
         for (int i = 0; i <= ncyc; i++) begin
            bx = 1'($urandom);
            e  = ($urandom_range(0, 3) == 0);
            ec = 4'($urandom);
            ab = ($urandom_range(0, 9) == 0);
            if (bx) nbytes++;
            if (e && ferr == 4'h0) ferr = ec;
            if (ab) aborted = 1'b1;
            step(bx, e, ec, ab, (i == ncyc));
         end
         exp = model(tid, wroc, rnw, sre, int'(len), nbytes, ferr, aborted);
         checks++;
         if (resp_valid !== exp[32] || busy !== exp[32] || (exp[32] && resp_desc !== exp[31:0])) begin
            errors++;
            $display("FAIL rand_%0d: valid=%b busy=%b desc=%h required %b %b %h",
                     n, resp_valid, busy, resp_desc, exp[32], exp[32], exp[31:0]);
         end
         if (exp[32]) begin
            dly = $urandom_range(0, 3);
            repeat (dly) tick();
            resp_ready = 1'b1; tick(); resp_ready = 1'b0;
            checks++;
            if (resp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
               errors++;
               $display("FAIL rand_accept_%0d: valid=%b ready=%b required 0 1",
                        n, resp_valid, cmd_ready);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_write_wroc();
      test_short_read();
      test_no_resp();
      test_errors();
      test_backpressure();
      test_random();
      test_saturation();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
